ssd1306_spi_streamer: RTL and testbench
=======================================

Name: ssd1306_spi_streamer

Overview:
- Downstream consumer of the graph/pixel generator. It drives the SSD1306 0.96" OLED over 4-wire SPI.
- After power-up it runs the panel hard-reset sequence and a fixed init command list.
- It then streams 128x8 page bytes (1024 per frame) forever, presenting `pixelAddress` and sampling `pixelData` from the upstream renderer.

Parameters:
- STARTUP_WAIT, 270000, cycle count for each of the three hard-reset phases (10 ms at 27 MHz).
- CLK_DIV, 1, clk cycles per SCLK half-period (1..255). SCLK period = 2*CLK_DIV.
- PIXEL_LAT, 2, clk cycles between a `pixelAddress` update and the `pixelData` sample (1..7). Covers the upstream registered lookup.

Ports:
- clk, input, 1, system clock (27 MHz board oscillator).
- rst_n, input, 1, asynchronous active-low reset.
- ioReset, output, 1, panel RES#, active-low.
- ioCs, output, 1, SPI chip-select, active-low.
- ioSclk, output, 1, SPI clock, idle low.
- ioSdin, output, 1, SPI MOSI, MSB first.
- ioDc, output, 1, 0 = command byte, 1 = display data byte.
- pixelAddress, output, 10, current byte address: [6:0] column, [9:7] page.
- pixelData, input, 8, column byte for `pixelAddress`; bit0 = top pixel of the page.
- init_done, output, 1, high once the init list has been sent; sticky until reset.
- frame_start, output, 1, one-cycle pulse when address 0 is loaded for a new frame.

Behaviour:
- Single clock domain. Only `rst_n` is asynchronous: assertion clears state immediately; deassertion is used as-is (synchronised externally).
- Reset values:
  - ioReset=1, ioCs=1, ioSclk=0, ioSdin=0, ioDc=0.
  - pixelAddress=0, init_done=0, frame_start=0.
  - FSM=ST_WAIT_HI, cmd index=0, bit counter=7.
- FSM states and transitions:
  - ST_WAIT_HI: ioReset=1 for STARTUP_WAIT cycles -> ST_RST_LO.
  - ST_RST_LO: ioReset=0 for STARTUP_WAIT cycles -> ST_WAIT_POST.
  - ST_WAIT_POST: ioReset=1 for STARTUP_WAIT cycles -> ST_LOAD_CMD.
  - ST_LOAD_CMD: loads ROM[idx] into the shift register, ioDc=0, ioCs=0 -> ST_SEND.
  - ROM, 10 bytes, in order: AE, 20, 00, 8D, 14, A1, C8, 81, 7F, AF.
  - ST_SEND: shifts 8 bits, then goes to ST_NEXT.
    - Per bit: ioSdin updated with ioSclk low, held CLK_DIV cycles; then ioSclk=1 for CLK_DIV cycles.
    - After bit0's high phase, ioSclk returns low in the same cycle as the exit.
    - One byte occupies exactly 16*CLK_DIV cycles in ST_SEND.
  - ST_NEXT, command phase: if idx<9, idx++ -> ST_LOAD_CMD. Else init_done<=1, pixelAddress<=0, frame_start pulse -> ST_PIX_WAIT.
  - ST_NEXT, data phase: pixelAddress increments mod 1024. On wrap to 0, frame_start pulses for one cycle. -> ST_PIX_WAIT.
  - ST_PIX_WAIT: counts PIXEL_LAT cycles, then samples `pixelData` into the shift register with ioDc=1 -> ST_SEND.
- `pixelAddress` is stable from ST_NEXT through the sample cycle. The upstream block may use it combinationally and register once.
- ioCs stays low continuously from the first ST_LOAD_CMD until reset; there is no per-byte deassert.
- ioDc changes only while ioSclk=0 and never during a byte.
- Wrap: address 1023 -> 0 with no gap beyond the normal ST_NEXT/ST_PIX_WAIT cycles. Frame N+1 follows frame N directly (horizontal addressing mode auto-wraps the panel).
- Reset mid-byte or mid-frame: all outputs return to reset values on the rst_n falling edge. The full hard-reset and init sequence is redone on release.
- Counters are sized for max(STARTUP_WAIT, CLK_DIV, PIXEL_LAT); no overflow within a phase.

Optional Feature:
- Macro: SCREEN_RESYNC_EN.
- Defined:
  - Before every frame (including the first), send 6 command bytes with ioDc=0: 21, 00, 7F, 22, 00, 07 (column 0-127, page 0-7).
  - Then load address 0. frame_start pulses when address 0 is loaded, after the resync bytes.
  - Guards against lost SCLK edges.
- Undefined: no resync bytes; frames stream back-to-back as above.

Test Plan:
- Setup: STARTUP_WAIT=4, CLK_DIV=1, PIXEL_LAT=2; rst_n released at t0.
  - ioReset high for cycles 0-3, low for 4-7, high for 8-11.
  - ioCs falls at cycle 12.
- Init capture: decode the MOSI bytes on SCLK rising edges -> exactly AE,20,00,8D,14,A1,C8,81,7F,AF, all with ioDc=0.
  - init_done rises after the AF byte.
  - Each byte spans 16 clk cycles.
- Pixel stream: upstream model returns pixelData = pixelAddress[7:0] registered one cycle.
  - Decoded data bytes = 00,01,...,FF,00,... repeating.
  - ioDc=1 throughout; 1024 bytes per frame.
- Wrap: byte after address 1023 carries address 0 data. frame_start pulses exactly once per 1024 bytes and never elsewhere.
- Async reset: assert rst_n at bit 4 of a data byte.
  - Same cycle: ioCs=1, ioSclk=0, ioReset=1, pixelAddress=0.
  - After release, the full reset/init sequence repeats.
- SCREEN_RESYNC_EN defined: frames 1 and 2 are each preceded by 21,00,7F,22,00,07 with ioDc=0. frame_start pulses after the 07 byte.

Source files
------------

// File: rtl/ssd1306_spi_streamer.sv
// SSD1306 4-wire SPI streamer: panel hard reset, init command list, then endless 128x8 page-byte frames.
// Optional SCREEN_RESYNC_EN: re-send the column/page window commands before every frame.
module ssd1306_spi_streamer #(
    parameter int STARTUP_WAIT = 270000,
    parameter int CLK_DIV      = 1,
    parameter int PIXEL_LAT    = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       ioReset,
    output logic       ioCs,
    output logic       ioSclk,
    output logic       ioSdin,
    output logic       ioDc,
    output logic [9:0] pixelAddress,
    input  logic [7:0] pixelData,
    output logic       init_done,
    output logic       frame_start
);

    localparam int MAX_A   = (STARTUP_WAIT > CLK_DIV) ? STARTUP_WAIT : CLK_DIV;
    localparam int MAX_CNT = (MAX_A > PIXEL_LAT) ? MAX_A : PIXEL_LAT;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(STARTUP_WAIT - 1);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] LAT_LAST  = CNT_W'(PIXEL_LAT - 1);

    localparam logic [3:0] INIT_LAST    = 4'd9;
    localparam logic [3:0] RESYNC_FIRST = 4'd10;
`ifdef SCREEN_RESYNC_EN
    localparam logic [3:0] LAST_CMD = 4'd15;
`else
    localparam logic [3:0] LAST_CMD = 4'd9;
`endif

    typedef enum logic [2:0] {
        ST_WAIT_HI,
        ST_RST_LO,
        ST_WAIT_POST,
        ST_LOAD_CMD,
        ST_SEND,
        ST_NEXT,
        ST_PIX_WAIT
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       cmd_idx;
    logic [2:0]       bit_cnt;
    logic [7:0]       shreg;
    logic [7:0]       rom_byte;

    // Entries 0..9 are the init list, 10..15 the window resync (column 0-127, page 0-7).
    function automatic logic [7:0] cmd_rom(input logic [3:0] idx);
        case (idx)
            4'd0:    cmd_rom = 8'hAE;
            4'd1:    cmd_rom = 8'h20;
            4'd2:    cmd_rom = 8'h00;
            4'd3:    cmd_rom = 8'h8D;
            4'd4:    cmd_rom = 8'h14;
            4'd5:    cmd_rom = 8'hA1;
            4'd6:    cmd_rom = 8'hC8;
            4'd7:    cmd_rom = 8'h81;
            4'd8:    cmd_rom = 8'h7F;
            4'd9:    cmd_rom = 8'hAF;
            4'd10:   cmd_rom = 8'h21;
            4'd11:   cmd_rom = 8'h00;
            4'd12:   cmd_rom = 8'h7F;
            4'd13:   cmd_rom = 8'h22;
            4'd14:   cmd_rom = 8'h00;
            4'd15:   cmd_rom = 8'h07;
            default: cmd_rom = 8'h00;
        endcase
    endfunction

    assign rom_byte = cmd_rom(cmd_idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_WAIT_HI;
            cnt          <= '0;
            cmd_idx      <= 4'd0;
            bit_cnt      <= 3'd7;
            shreg        <= 8'h00;
            ioReset      <= 1'b1;
            ioCs         <= 1'b1;
            ioSclk       <= 1'b0;
            ioSdin       <= 1'b0;
            ioDc         <= 1'b0;
            pixelAddress <= 10'd0;
            init_done    <= 1'b0;
            frame_start  <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            case (state)
                ST_WAIT_HI: begin
                    if (cnt == WAIT_LAST) begin
                        cnt     <= '0;
                        ioReset <= 1'b0;
                        state   <= ST_RST_LO;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_RST_LO: begin
                    if (cnt == WAIT_LAST) begin
                        cnt     <= '0;
                        ioReset <= 1'b1;
                        state   <= ST_WAIT_POST;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_WAIT_POST: begin
                    if (cnt == WAIT_LAST) begin
                        cnt   <= '0;
                        state <= ST_LOAD_CMD;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_LOAD_CMD: begin
                    shreg   <= rom_byte;
                    ioSdin  <= rom_byte[7];
                    ioDc    <= 1'b0;
                    ioCs    <= 1'b0;
                    bit_cnt <= 3'd7;
                    cnt     <= '0;
                    state   <= ST_SEND;
                end
                ST_SEND: begin
                    // MOSI is already valid on entry; each half-period ends on cnt == DIV_LAST.
                    if (cnt == DIV_LAST) begin
                        cnt <= '0;
                        if (!ioSclk) begin
                            ioSclk <= 1'b1;
                        end else begin
                            ioSclk <= 1'b0;
                            if (bit_cnt == 3'd0) begin
                                state <= ST_NEXT;
                            end else begin
                                bit_cnt <= bit_cnt - 3'd1;
                                shreg   <= {shreg[6:0], 1'b0};
                                ioSdin  <= shreg[6];
                            end
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_NEXT: begin
                    // ioDc still describes the byte just sent, so it selects command vs data phase.
                    if (!ioDc) begin
                        if (cmd_idx == INIT_LAST) begin
                            init_done <= 1'b1;
                        end
                        if (cmd_idx != LAST_CMD) begin
                            cmd_idx <= cmd_idx + 4'd1;
                            state   <= ST_LOAD_CMD;
                        end else begin
                            pixelAddress <= 10'd0;
                            frame_start  <= 1'b1;
                            cnt          <= '0;
                            state        <= ST_PIX_WAIT;
                        end
                    end else begin
                        pixelAddress <= pixelAddress + 10'd1;
`ifdef SCREEN_RESYNC_EN
                        if (pixelAddress == 10'd1023) begin
                            cmd_idx <= RESYNC_FIRST;
                            state   <= ST_LOAD_CMD;
                        end else begin
                            cnt   <= '0;
                            state <= ST_PIX_WAIT;
                        end
`else
                        if (pixelAddress == 10'd1023) begin
                            frame_start <= 1'b1;
                        end
                        cnt   <= '0;
                        state <= ST_PIX_WAIT;
`endif
                    end
                end
                ST_PIX_WAIT: begin
                    if (cnt == LAT_LAST) begin
                        shreg   <= pixelData;
                        ioSdin  <= pixelData[7];
                        ioDc    <= 1'b1;
                        bit_cnt <= 3'd7;
                        cnt     <= '0;
                        state   <= ST_SEND;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_WAIT_HI;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ssd1306_spi_streamer.sv
// Bench for ssd1306_spi_streamer: SPI byte decoder feeding a scoreboard of expected {dc, byte} entries.
module tb_ssd1306_spi_streamer;

    localparam int STARTUP_WAIT = 4;
    localparam int CLK_DIV      = 1;
    localparam int PIXEL_LAT    = 2;
    localparam int BYTE_SPAN    = 2 * CLK_DIV * 7;

    localparam logic [7:0] CMD_LIST [16] = '{
        8'hAE, 8'h20, 8'h00, 8'h8D, 8'h14, 8'hA1, 8'hC8, 8'h81,
        8'h7F, 8'hAF, 8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07
    };

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       io_reset, io_cs, io_sclk, io_sdin, io_dc;
    logic [9:0] pixel_address;
    logic [7:0] pixel_data = 8'h00;
    logic       init_done, frame_start;

    ssd1306_spi_streamer #(
        .STARTUP_WAIT(STARTUP_WAIT),
        .CLK_DIV     (CLK_DIV),
        .PIXEL_LAT   (PIXEL_LAT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ioReset     (io_reset),
        .ioCs        (io_cs),
        .ioSclk      (io_sclk),
        .ioSdin      (io_sdin),
        .ioDc        (io_dc),
        .pixelAddress(pixel_address),
        .pixelData   (pixel_data),
        .init_done   (init_done),
        .frame_start (frame_start)
    );

    // clock / upstream renderer model (registered lookup: data = address[7:0])
    always #5 clk = ~clk;
    always @(posedge clk) pixel_data <= pixel_address[7:0];

    logic [8:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_cmds(input int first, input int last);
        for (int i = first; i <= last; i++) exp_q.push_back({1'b0, CMD_LIST[i]});
    endtask

    task automatic push_frame(input int n_bytes);
`ifdef SCREEN_RESYNC_EN
        push_cmds(10, 15);
`endif
        for (int a = 0; a < n_bytes; a++) exp_q.push_back({1'b1, 8'(a)});
    endtask

    // Edges counted from release: RES# goes low on edge SW-1, back high on edge 2*SW-1, CS# falls on edge 3*SW.
    task automatic check_reset_seq(input string tag);
        int first_lo = -1;
        int lo_cnt = 0;
        int cs_fall = -1;
        for (int k = 0; k < 3 * STARTUP_WAIT + 4; k++) begin
            @(posedge clk); #1;
            if (!io_reset) begin
                lo_cnt++;
                if (first_lo < 0) first_lo = k;
            end
            if (!io_cs && cs_fall < 0) cs_fall = k;
        end
        check({tag, "_res_lo_edge"}, first_lo, STARTUP_WAIT - 1);
        check({tag, "_res_lo_len"}, lo_cnt, STARTUP_WAIT);
        check({tag, "_cs_fall_edge"}, cs_fall, 3 * STARTUP_WAIT);
    endtask

    task automatic wait_q(input int left, input int budget, input string name);
        int k = 0;
        while (exp_q.size() > left && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, exp_q.size(), left);
    endtask

    // monitor: decode MOSI on SCLK rising edges, sampled on the falling clk edge
    int         mon_bits = 0;
    logic [7:0] mon_byte = 8'h00;
    logic       mon_dc = 1'b0;
    logic       prev_sclk = 1'b0;
    int         cyc = 0;
    int         first_cyc = 0;
    int         data_seen = 0;
    int         fs_count = 0;
    logic [8:0] exp_e;

    always @(negedge clk) begin
        if (!rst_n) begin
            mon_bits  = 0;
            prev_sclk = 1'b0;
            data_seen = 0;
        end else begin
            cyc++;
            if (io_sclk && !prev_sclk) begin
                if (mon_bits == 0) begin
                    first_cyc = cyc;
                    mon_dc    = io_dc;
                end
                mon_byte = {mon_byte[6:0], io_sdin};
                mon_bits++;
                if (mon_bits == 8) begin
                    mon_bits = 0;
                    check("byte_span", cyc - first_cyc, BYTE_SPAN);
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_byte: got dc=%0b byte=%02h expected none", mon_dc, mon_byte);
                    end else begin
                        exp_e = exp_q.pop_front();
                        check("spi_byte", {mon_dc, mon_byte}, exp_e);
                    end
                    if (!mon_dc && mon_byte == 8'hAF) check("init_done_not_early", init_done, 1'b0);
                    if (mon_dc) data_seen++;
                end
            end
            if (frame_start) begin
                fs_count++;
                check("frame_start_pos", data_seen % 1024, 0);
                check("frame_start_addr", pixel_address, 10'd0);
                check("init_done_at_frame", init_done, 1'b1);
            end
            prev_sclk = io_sclk;
        end
    end

    initial begin
        int k;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_io_reset", io_reset, 1'b1);
        check("rst_io_cs", io_cs, 1'b1);
        check("rst_io_sclk", io_sclk, 1'b0);
        check("rst_io_sdin", io_sdin, 1'b0);
        check("rst_io_dc", io_dc, 1'b0);
        check("rst_pixel_address", pixel_address, 10'd0);
        check("rst_init_done", init_done, 1'b0);
        check("rst_frame_start", frame_start, 1'b0);

        // run 1: init list, a full frame, then 21 bytes into frame 2 (the last one gets interrupted)
        @(negedge clk);
        rst_n = 1'b1;
        push_cmds(0, 9);
        push_frame(1024);
        push_frame(21);
        check_reset_seq("run1");
        wait_q(1, 40000, "run1_drain");
        check("run1_frame_starts", fs_count, 2);
        check("run1_init_done", init_done, 1'b1);

        k = 0;
        while (!(mon_bits == 4 && mon_dc) && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("reached_data_bit4", mon_bits, 4);
        #2;
        rst_n = 1'b0;
        #1;
        check("midbyte_io_cs", io_cs, 1'b1);
        check("midbyte_io_sclk", io_sclk, 1'b0);
        check("midbyte_io_reset", io_reset, 1'b1);
        check("midbyte_pixel_address", pixel_address, 10'd0);
        check("midbyte_io_sdin", io_sdin, 1'b0);
        check("midbyte_io_dc", io_dc, 1'b0);
        check("midbyte_init_done", init_done, 1'b0);
        exp_q.delete();

        // run 2: full reset/init sequence must repeat after release
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        push_cmds(0, 9);
        push_frame(3);
        check_reset_seq("run2");
        wait_q(0, 3000, "run2_drain");
        check("run2_frame_starts", fs_count, 3);
        check("run2_init_done", init_done, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
